mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O controller for the 16-bit processor's data-memory bus in the I/O window 0xFFF0–0xFFFF.
- Consumes the processor's data address, store data and store enable. Drives the seven-segment digits, red LEDs and green LEDs.
- Produces read data for loads: debounced KEY/SW levels and sticky key-press flags.
- Replaces raw KEY/SW reads and ad-hoc output latching in the top level.

Parameters:
DBITS, 16, data/address width
DEB_CYCLES, 50000, clock cycles between debounce sample ticks (≥2)
DEB_SAMPLES, 3, consecutive equal samples required to accept a new level (≥2)
CNTBITS, 16, width of the tick prescaler; must hold DEB_CYCLES-1

Ports:
CLK  in  1  system clock (PLL output)
RESET_N  in  1  asynchronous active-low reset
ADDR  in  DBITS  data-memory address
WDATA  in  DBITS  store data
WE  in  1  store enable, sampled on posedge CLK
RDATA  out  DBITS  combinational read data
SEL  out  1  1 when ADDR[15:4]==12'hFFF
KEY_IN  in  4  raw pushbuttons, active-low, asynchronous
SW_IN  in  10  raw slide switches, asynchronous
HEX_OUT  out  16  four hex nibbles for the seven-segment decoders, [15:12]=HEX3
LEDR_OUT  out  10  red LEDs
LEDG_OUT  out  8  green LEDs

Behaviour:
- One clock: CLK. Reset is asynchronous and active-low on RESET_N. All flops clear immediately on RESET_N=0.
- Reset values:
  - HEX_OUT=0, LEDR_OUT=0, LEDG_OUT=0.
  - Key synchronizers, sample history and debounced keys = 4'hF (released).
  - Switch synchronizers, history and debounced switches = 0.
  - Press flags, overrun flags and prescaler = 0.
- Register map (word addresses; ADDR[0] ignored):
  - 0xFFF0 KDATA (R): {12'b0, deb_key[3:0]}.
  - 0xFFF2 SDATA (R): {6'b0, deb_sw[9:0]}.
  - 0xFFF4 KCTRL (R/W1C): [3:0] press flags, [7:4] overrun flags, rest 0.
  - 0xFFF8 HEX (R/W), 0xFFFA LEDR (R/W, bits [9:0]), 0xFFFC LEDG (R/W, bits [7:0]).
  - 0xFFF6, 0xFFFE: read 0, writes ignored.
- Reads:
  - Purely combinational from ADDR, zero latency.
  - RDATA=0 when SEL=0; the processor muxes on SEL.
- Writes:
  - Take effect at the posedge where WE=1, SEL=1 and the address matches.
  - Unused WDATA bits are ignored.
  - Writes to KDATA and SDATA have no effect.
- Synchronizer: two flops per KEY/SW bit.
- Prescaler:
  - Counts 0..DEB_CYCLES-1 and wraps to 0.
  - tick=1 for exactly one cycle when count==DEB_CYCLES-1.
- Debounce, per bit:
  - On tick, a DEB_SAMPLES-deep history shifts in the synchronized value.
  - If all history entries are equal and differ from the debounced level, the debounced level takes that value at the same edge.
  - A glitch shorter than DEB_SAMPLES ticks never changes the debounced level.
- Press detect: debounced key bit i transitions 1→0 (one-cycle pulse).
- KCTRL update per bit i, same edge:
  - Press flag: next = (flag & ~(clr_i)) | press_i, where clr_i = KCTRL write with WDATA[i]=1. Set wins over clear.
  - Overrun bit 4+i: sets when press_i occurs while flag i=1 and clr_i=0. Clears on a KCTRL write with WDATA[4+i]=1; set wins.
- Release (0→1) never sets a flag.
- Reset mid-debounce discards the history and the prescaler phase.

Test Plan:
- Run all tests with DEB_CYCLES=4, DEB_SAMPLES=3.
- Reset: assert RESET_N=0 mid-cycle → immediately HEX_OUT=0, LEDR_OUT=0, LEDG_OUT=0. After release, reading 0xFFF0 returns 0x000F and 0xFFF4 returns 0x0000.
- Output stores:
  - WE=1 to 0xFFF8 with 0xBEEF → HEX_OUT=0xBEEF after the edge; read 0xFFF8 returns 0xBEEF.
  - WE=1 to 0xFFFA with 0xFFFF → LEDR_OUT=0x3FF.
  - WE=1 to 0xFFF0 → no state change.
- Debounce accept: hold KEY_IN[0]=0 steadily → deb_key[0] falls after 2 sync cycles plus 3 ticks, i.e. ≤14 cycles. KCTRL reads 0x0001, then stays 0x0001 on release.
- Glitch reject: pulse KEY_IN[1]=0 for 6 cycles (<3 ticks), then 1 → KDATA stays 0x000F and KCTRL[1]=0.
- W1C and overrun:
  - Two debounced presses of key 2 without clearing → KCTRL=0x0044.
  - Write 0x0004 → KCTRL=0x0040.
  - Write 0x0040 → KCTRL=0x0000.
  - Press coinciding with a write of 0x0004 on the same edge → flag remains 1.
- Decode: ADDR=0x1FF0 → SEL=0, RDATA=0, and a write there leaves all outputs unchanged. ADDR=0xFFF3 reads SDATA, since bit 0 is ignored.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// I/O-window register block: debounced KEY/SW inputs with sticky press/overrun
// flags, plus latched HEX/LEDR/LEDG outputs, all decoded from 0xFFF0-0xFFFF.
module mmio_io_ctrl #(
  parameter int DBITS       = 16,
  parameter int DEB_CYCLES  = 50000,
  parameter int DEB_SAMPLES = 3,
  parameter int CNTBITS     = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DBITS-1:0] ADDR,
  input  logic [DBITS-1:0] WDATA,
  input  logic             WE,
  output logic [DBITS-1:0] RDATA,
  output logic             SEL,
  input  logic [3:0]       KEY_IN,
  input  logic [9:0]       SW_IN,
  output logic [15:0]      HEX_OUT,
  output logic [9:0]       LEDR_OUT,
  output logic [7:0]       LEDG_OUT
);

  // Keys occupy bits [3:0], switches [13:4]; keys idle high (released).
  localparam int          NB     = 14;
  localparam logic [NB-1:0] IN_RST = {10'b0, 4'hF};

  logic [NB-1:0]      in_p0, in_p1;
  logic [NB-1:0]      hist_q [DEB_SAMPLES];
  logic [NB-1:0]      hist_d [DEB_SAMPLES];
  logic [NB-1:0]      deb_q, deb_d, all_eq;
  logic [CNTBITS-1:0] cnt_q;
  logic               tick;
  logic [3:0]         flag_q, ovr_q, press, clr_flag, clr_ovr;
  logic [15:0]        hex_q;
  logic [9:0]         ledr_q;
  logic [7:0]         ledg_q;
  logic [2:0]         reg_idx;
  logic               wr_en;
  logic               unused_addr_lsb;

  assign SEL             = (ADDR[DBITS-1:4] == '1);
  assign reg_idx         = ADDR[3:1];
  assign wr_en           = WE & SEL;
  assign unused_addr_lsb = ADDR[0];
  assign tick            = (cnt_q == CNTBITS'(DEB_CYCLES - 1));
  assign clr_flag        = (wr_en && reg_idx == 3'd2) ? WDATA[3:0] : 4'b0;
  assign clr_ovr         = (wr_en && reg_idx == 3'd2) ? WDATA[7:4] : 4'b0;

  // The new level is judged on the history as it will be after this tick,
  // so the debounced bit moves on the same edge the last sample lands.
  always_comb begin
    hist_d = hist_q;
    if (tick) begin
      hist_d[0] = in_p1;
      for (int k = 1; k < DEB_SAMPLES; k++) hist_d[k] = hist_q[k-1];
    end
    all_eq = '1;
    for (int k = 1; k < DEB_SAMPLES; k++) all_eq = all_eq & ~(hist_d[k] ^ hist_d[0]);
    deb_d = tick ? ((deb_q & ~all_eq) | (hist_d[0] & all_eq)) : deb_q;
    press = deb_q[3:0] & ~deb_d[3:0];
  end

  // Stage p0 -> p1: two-flop synchronizer on the raw asynchronous inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_p0 <= IN_RST;
      in_p1 <= IN_RST;
    end else begin
      in_p0 <= {SW_IN, KEY_IN};
      in_p1 <= in_p0;
    end
  end

  // Stage p1 -> debounce: prescaled sampling history and accepted levels.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
      deb_q <= IN_RST;
      for (int k = 0; k < DEB_SAMPLES; k++) hist_q[k] <= IN_RST;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      deb_q <= deb_d;
      for (int k = 0; k < DEB_SAMPLES; k++) hist_q[k] <= hist_d[k];
    end
  end

  // Overrun is judged against the flag before this edge's update; set wins over clear.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flag_q <= 4'b0;
      ovr_q  <= 4'b0;
    end else begin
      flag_q <= (flag_q & ~clr_flag) | press;
      ovr_q  <= (ovr_q & ~clr_ovr) | (press & flag_q & ~clr_flag);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hex_q  <= 16'b0;
      ledr_q <= 10'b0;
      ledg_q <= 8'b0;
    end else if (wr_en) begin
      case (reg_idx)
        3'd4:    hex_q  <= WDATA[15:0];
        3'd5:    ledr_q <= WDATA[9:0];
        3'd6:    ledg_q <= WDATA[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    RDATA = '0;
    if (SEL) begin
      case (reg_idx)
        3'd0:    RDATA = DBITS'(deb_q[3:0]);
        3'd1:    RDATA = DBITS'(deb_q[13:4]);
        3'd2:    RDATA = DBITS'({ovr_q, flag_q});
        3'd4:    RDATA = DBITS'(hex_q);
        3'd5:    RDATA = DBITS'(ledr_q);
        3'd6:    RDATA = DBITS'(ledg_q);
        default: RDATA = '0;
      endcase
    end
  end

  assign HEX_OUT  = hex_q;
  assign LEDR_OUT = ledr_q;
  assign LEDG_OUT = ledg_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed register-map scenarios followed by random
// bus traffic and input toggling, all scored against a behavioural model.
module tb_mmio_io_ctrl;

  localparam int DC = 4;
  localparam int DS = 3;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] ADDR = 16'h0;
  logic [15:0] WDATA = 16'h0;
  logic        WE = 1'b0;
  logic [15:0] RDATA;
  logic        SEL;
  logic [3:0]  KEY_IN = 4'hF;
  logic [9:0]  SW_IN = 10'h0;
  logic [15:0] HEX_OUT;
  logic [9:0]  LEDR_OUT;
  logic [7:0]  LEDG_OUT;

  int n_vec = 0;
  int n_err = 0;

  mmio_io_ctrl #(.DBITS(16), .DEB_CYCLES(DC), .DEB_SAMPLES(DS), .CNTBITS(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .WDATA(WDATA), .WE(WE),
    .RDATA(RDATA), .SEL(SEL), .KEY_IN(KEY_IN), .SW_IN(SW_IN),
    .HEX_OUT(HEX_OUT), .LEDR_OUT(LEDR_OUT), .LEDG_OUT(LEDG_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state: bit b of the 14-bit vectors is KEY (b<4) or SW (b>=4).
  logic [13:0] m_s0, m_s1, m_deb;
  logic [13:0] m_hist [DS];
  logic [3:0]  m_flag, m_ovr;
  int          m_cnt;
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:4] != 12'hFFF) return 16'h0;
    case (a[3:1])
      3'd0:    return {12'h0, m_deb[3:0]};
      3'd1:    return {6'h0, m_deb[13:4]};
      3'd2:    return {8'h0, m_ovr, m_flag};
      3'd4:    return m_hex;
      3'd5:    return {6'h0, m_ledr};
      3'd6:    return {8'h0, m_ledg};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_s0 = 14'h000F; m_s1 = 14'h000F; m_deb = 14'h000F;
    for (int k = 0; k < DS; k++) m_hist[k] = 14'h000F;
    m_flag = 4'h0; m_ovr = 4'h0; m_cnt = 0;
    m_hex = 16'h0; m_ledr = 10'h0; m_ledg = 8'h0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    logic [3:0] press, clr, clro;
    logic       eq;
    press = 4'h0;
    if (m_cnt == DC - 1) begin
      for (int k = DS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_s1;
      for (int b = 0; b < 14; b++) begin
        eq = 1'b1;
        for (int k = 1; k < DS; k++) if (m_hist[k][b] != m_hist[0][b]) eq = 1'b0;
        if (eq && m_hist[0][b] != m_deb[b]) begin
          if (b < 4 && m_deb[b]) press[b] = 1'b1;
          m_deb[b] = m_hist[0][b];
        end
      end
    end
    m_s1 = m_s0;
    m_s0 = {SW_IN, KEY_IN};
    clr = 4'h0; clro = 4'h0;
    if (WE && ADDR[15:4] == 12'hFFF) begin
      case (ADDR[3:1])
        3'd2: begin clr = WDATA[3:0]; clro = WDATA[7:4]; end
        3'd4: m_hex = WDATA;
        3'd5: m_ledr = WDATA[9:0];
        3'd6: m_ledg = WDATA[7:0];
        default: ;
      endcase
    end
    m_ovr  = (m_ovr & ~clro) | (press & m_flag & ~clr);
    m_flag = (m_flag & ~clr) | press;
    m_cnt  = (m_cnt + 1) % DC;
  endtask

  function automatic logic key2_press_next();
    return (m_cnt == DC - 1) && !m_s1[2] && !m_hist[0][2] && !m_hist[1][2] && m_deb[2];
  endfunction

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("sel", 32'(SEL), 32'(ADDR[15:4] == 12'hFFF));
    chk("rdata", 32'(RDATA), 32'(m_read(ADDR)));
    chk("hex", 32'(HEX_OUT), 32'(m_hex));
    chk("ledr", 32'(LEDR_OUT), 32'(m_ledr));
    chk("ledg", 32'(LEDG_OUT), 32'(m_ledg));
    model_update();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    WE = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    ADDR = a; WDATA = d; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    ADDR = a; WE = 1'b0;
    #1;
    chk(tag, 32'(RDATA), 32'(exp));
    step();
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hit;
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_hex", 32'(HEX_OUT), 32'h0);
    chk("rst_ledr", 32'(LEDR_OUT), 32'h0);
    RESET_N = 1'b1;
    @(negedge CLK);
    idle(2);
    rd_chk("kdata_rst", 16'hFFF0, 16'h000F);
    rd_chk("kctrl_rst", 16'hFFF4, 16'h0000);

    // Output stores
    wr(16'hFFF8, 16'hBEEF);
    chk("hex_store", 32'(HEX_OUT), 32'h0000BEEF);
    rd_chk("hex_read", 16'hFFF8, 16'hBEEF);
    wr(16'hFFFA, 16'hFFFF);
    chk("ledr_store", 32'(LEDR_OUT), 32'h3FF);
    wr(16'hFFFC, 16'h12A5);
    chk("ledg_store", 32'(LEDG_OUT), 32'hA5);
    wr(16'hFFF0, 16'h1234);
    chk("kdata_wr_hex", 32'(HEX_OUT), 32'h0000BEEF);
    rd_chk("kdata_wr", 16'hFFF0, 16'h000F);

    // Asynchronous reset in the middle of a high phase
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_hex", 32'(HEX_OUT), 32'h0);
    chk("midrst_ledr", 32'(LEDR_OUT), 32'h0);
    chk("midrst_ledg", 32'(LEDG_OUT), 32'h0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    idle(2);
    rd_chk("kdata_after_rst", 16'hFFF0, 16'h000F);
    rd_chk("kctrl_after_rst", 16'hFFF4, 16'h0000);

    // Debounce accept on key 0, then release
    KEY_IN[0] = 1'b0;
    idle(14);
    rd_chk("deb_accept", 16'hFFF0, 16'h000E);
    rd_chk("kctrl_press", 16'hFFF4, 16'h0001);
    KEY_IN[0] = 1'b1;
    idle(20);
    rd_chk("deb_release", 16'hFFF0, 16'h000F);
    rd_chk("kctrl_release", 16'hFFF4, 16'h0001);

    // Glitch shorter than three ticks on key 1
    KEY_IN[1] = 1'b0;
    idle(6);
    KEY_IN[1] = 1'b1;
    idle(20);
    rd_chk("glitch_kdata", 16'hFFF0, 16'h000F);
    rd_chk("glitch_kctrl", 16'hFFF4, 16'h0001);

    // W1C and overrun on key 2
    wr(16'hFFF4, 16'h00FF);
    rd_chk("kctrl_cleared", 16'hFFF4, 16'h0000);
    repeat (2) begin
      KEY_IN[2] = 1'b0; idle(16);
      KEY_IN[2] = 1'b1; idle(16);
    end
    rd_chk("kctrl_overrun", 16'hFFF4, 16'h0044);
    wr(16'hFFF4, 16'h0004);
    rd_chk("kctrl_w1c_flag", 16'hFFF4, 16'h0040);
    wr(16'hFFF4, 16'h0040);
    rd_chk("kctrl_w1c_ovr", 16'hFFF4, 16'h0000);

    // Press landing on the same edge as a clearing write
    KEY_IN[2] = 1'b0;
    ADDR = 16'hFFF4;
    hit = 1'b0;
    for (int i = 0; i < 24 && !hit; i++) begin
      if (key2_press_next()) begin
        hit = 1'b1;
        wr(16'hFFF4, 16'h0004);
      end else begin
        step();
      end
    end
    chk("coincide_seen", 32'(hit), 32'h1);
    rd_chk("kctrl_set_wins", 16'hFFF4, 16'h0004);
    KEY_IN[2] = 1'b1;
    idle(16);
    wr(16'hFFF4, 16'h00FF);

    // Address decode
    ADDR = 16'h1FF0;
    #1;
    chk("decode_sel", 32'(SEL), 32'h0);
    chk("decode_rdata", 32'(RDATA), 32'h0);
    step();
    wr(16'h1FF8, 16'h1234);
    wr(16'h1FFA, 16'h03FF);
    chk("decode_hex", 32'(HEX_OUT), 32'h0);
    chk("decode_ledr", 32'(LEDR_OUT), 32'h0);
    SW_IN = 10'h2A5;
    idle(16);
    rd_chk("sdata_odd_addr", 16'hFFF3, 16'h02A5);

    // Random traffic with slowly changing inputs
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) KEY_IN[$urandom_range(3)] = ~KEY_IN[$urandom_range(3)];
      if ($urandom_range(39) == 0) SW_IN = 10'($urandom);
      if ($urandom_range(7) == 0) ADDR = 16'($urandom);
      else ADDR = {12'hFFF, 4'($urandom)};
      WE = ($urandom_range(3) == 0);
      WDATA = 16'($urandom);
      step();
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
